// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data_mem port: core load/store path vs. DMA/debug.
// Tracks one outstanding read, returns it with rvalid, and raises core_stall_o while the core must wait.
module dmem_arbiter #(
    parameter int AddressWidth = 10,
    parameter int ReadLatency  = 1,
    parameter int MaxBurst     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    core_req_i,
    input  logic                    core_we_i,
    input  logic [AddressWidth-1:0] core_addr_i,
    input  logic [31:0]             core_wdata_i,
    input  logic [2:0]              core_funct3_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [31:0]             core_rdata_o,
    input  logic                    dma_req_i,
    input  logic                    dma_we_i,
    input  logic [AddressWidth-1:0] dma_addr_i,
    input  logic [31:0]             dma_wdata_i,
    input  logic [2:0]              dma_funct3_i,
    output logic                    dma_gnt_o,
    output logic                    dma_rvalid_o,
    output logic [31:0]             dma_rdata_o,
    output logic                    mem_r_en_o,
    output logic                    mem_wr_en_o,
    output logic [AddressWidth-1:0] mem_addr_o,
    output logic [31:0]             mem_wr_data_o,
    output logic [2:0]              mem_funct3_o,
    input  logic [31:0]             mem_r_data_i,
    output logic                    core_stall_o
);

    if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
        $error("dmem_arbiter: ReadLatency must be in 1..4");
    end
    if (MaxBurst < 1) begin : g_bad_burst
        $error("dmem_arbiter: MaxBurst must be at least 1");
    end

    localparam int LatW    = 2;
    localparam int StarveW = $clog2(MaxBurst + 1);
    localparam logic [LatW-1:0]    LatZero    = {LatW{1'b0}};
    localparam logic [LatW-1:0]    LatOne     = LatW'(1);
    localparam logic [LatW-1:0]    LatLoad    = LatW'(ReadLatency - 1);
    localparam logic [StarveW-1:0] StarveZero = {StarveW{1'b0}};
    localparam logic [StarveW-1:0] StarveOne  = StarveW'(1);
    localparam logic [StarveW-1:0] StarveMax  = StarveW'(MaxBurst);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_READ = 1'b1} state_t;
    typedef enum logic [0:0] {OWN_CORE = 1'b0, OWN_DMA = 1'b1} owner_t;

    state_t                  state_r, state_next_s;
    owner_t                  owner_r;
    logic [LatW-1:0]         lat_cnt_r;
    logic [StarveW-1:0]      starve_cnt_r;
    logic                    starve_full_s;
    logic                    core_gnt_s, dma_gnt_s;
    logic                    core_rvalid_s, dma_rvalid_s;
    logic [31:0]             core_rdata_s, dma_rdata_s;
    logic                    mem_r_en_s, mem_wr_en_s;
    logic [AddressWidth-1:0] mem_addr_s;
    logic [31:0]             mem_wr_data_s;
    logic [2:0]              mem_funct3_s;
    logic                    core_stall_s;

    assign starve_full_s = (starve_cnt_r == StarveMax);

    // Grant decision, memory payload mux, read return and next state; everything is forced low in reset.
    always_comb begin
        state_next_s  = state_r;
        core_gnt_s    = 1'b0;
        dma_gnt_s     = 1'b0;
        core_rvalid_s = 1'b0;
        dma_rvalid_s  = 1'b0;
        core_rdata_s  = 32'h0000_0000;
        dma_rdata_s   = 32'h0000_0000;
        mem_r_en_s    = 1'b0;
        mem_wr_en_s   = 1'b0;
        mem_addr_s    = {AddressWidth{1'b0}};
        mem_wr_data_s = 32'h0000_0000;
        mem_funct3_s  = 3'b000;
        core_stall_s  = 1'b0;
        if (rst_i) begin
            case (state_r)
                IDLE: begin
                    // Core wins ties unless DMA has already waited through MaxBurst core grants.
                    if (core_req_i && !(dma_req_i && starve_full_s)) begin
                        core_gnt_s = 1'b1;
                    end else if (dma_req_i) begin
                        dma_gnt_s = 1'b1;
                    end else begin
                        core_gnt_s = 1'b0;
                    end
                    if (core_gnt_s) begin
                        mem_r_en_s    = ~core_we_i;
                        mem_wr_en_s   = core_we_i;
                        mem_addr_s    = core_addr_i;
                        mem_wr_data_s = core_wdata_i;
                        mem_funct3_s  = core_funct3_i;
                    end else if (dma_gnt_s) begin
                        mem_r_en_s    = ~dma_we_i;
                        mem_wr_en_s   = dma_we_i;
                        mem_addr_s    = dma_addr_i;
                        mem_wr_data_s = dma_wdata_i;
                        mem_funct3_s  = dma_funct3_i;
                    end else begin
                        mem_r_en_s = 1'b0;
                    end
                    if (mem_r_en_s) begin
                        state_next_s = WAIT_READ;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                WAIT_READ: begin
                    if (lat_cnt_r == LatZero) begin
                        state_next_s = IDLE;
                        if (owner_r == OWN_DMA) begin
                            dma_rvalid_s = 1'b1;
                            dma_rdata_s  = mem_r_data_i;
                        end else begin
                            core_rvalid_s = 1'b1;
                            core_rdata_s  = mem_r_data_i;
                        end
                    end else begin
                        state_next_s = WAIT_READ;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
            core_stall_s = (core_req_i & ~core_gnt_s) |
                           ((state_r == WAIT_READ) & (owner_r == OWN_CORE) & ~core_rvalid_s);
        end else begin
            state_next_s = IDLE;
        end
    end

    // State, read owner, latency countdown and DMA starvation counter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            owner_r      <= OWN_CORE;
            lat_cnt_r    <= LatZero;
            starve_cnt_r <= StarveZero;
        end else begin
            state_r <= state_next_s;
            if (mem_r_en_s) begin
                owner_r   <= dma_gnt_s ? OWN_DMA : OWN_CORE;
                lat_cnt_r <= LatLoad;
            end else if (state_r == WAIT_READ && lat_cnt_r != LatZero) begin
                lat_cnt_r <= lat_cnt_r - LatOne;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
            if (!dma_req_i || dma_gnt_s) begin
                starve_cnt_r <= StarveZero;
            end else if (core_gnt_s && !starve_full_s) begin
                starve_cnt_r <= starve_cnt_r + StarveOne;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end
    end

    assign core_gnt_o    = core_gnt_s;
    assign dma_gnt_o     = dma_gnt_s;
    assign core_rvalid_o = core_rvalid_s;
    assign dma_rvalid_o  = dma_rvalid_s;
    assign core_rdata_o  = core_rdata_s;
    assign dma_rdata_o   = dma_rdata_s;
    assign mem_r_en_o    = mem_r_en_s;
    assign mem_wr_en_o   = mem_wr_en_s;
    assign mem_addr_o    = mem_addr_s;
    assign mem_wr_data_o = mem_wr_data_s;
    assign mem_funct3_o  = mem_funct3_s;
    assign core_stall_o  = core_stall_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (ReadLatency 1 and 3) share one stimulus stream and are checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req, core_we, dma_req, dma_we;
    logic [9:0]  core_addr, dma_addr;
    logic [31:0] core_wdata, dma_wdata, mem_rdata;
    logic [2:0]  core_f3, dma_f3;

    logic [1:0]       core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_ren, mem_wen, stall;
    logic [1:0][31:0] core_rdata, dma_rdata, mem_wd;
    logic [1:0][9:0]  mem_addr;
    logic [1:0][2:0]  mem_f3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AddressWidth(10), .ReadLatency(1), .MaxBurst(MB)) u_l1 (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_funct3_i(core_f3),
        .core_gnt_o(core_gnt[0]), .core_rvalid_o(core_rvalid[0]), .core_rdata_o(core_rdata[0]),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_wdata_i(dma_wdata), .dma_funct3_i(dma_f3),
        .dma_gnt_o(dma_gnt[0]), .dma_rvalid_o(dma_rvalid[0]), .dma_rdata_o(dma_rdata[0]),
        .mem_r_en_o(mem_ren[0]), .mem_wr_en_o(mem_wen[0]), .mem_addr_o(mem_addr[0]),
        .mem_wr_data_o(mem_wd[0]), .mem_funct3_o(mem_f3[0]), .mem_r_data_i(mem_rdata),
        .core_stall_o(stall[0])
    );

    dmem_arbiter #(.AddressWidth(10), .ReadLatency(3), .MaxBurst(MB)) u_l3 (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_funct3_i(core_f3),
        .core_gnt_o(core_gnt[1]), .core_rvalid_o(core_rvalid[1]), .core_rdata_o(core_rdata[1]),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_wdata_i(dma_wdata), .dma_funct3_i(dma_f3),
        .dma_gnt_o(dma_gnt[1]), .dma_rvalid_o(dma_rvalid[1]), .dma_rdata_o(dma_rdata[1]),
        .mem_r_en_o(mem_ren[1]), .mem_wr_en_o(mem_wen[1]), .mem_addr_o(mem_addr[1]),
        .mem_wr_data_o(mem_wd[1]), .mem_funct3_o(mem_f3[1]), .mem_r_data_i(mem_rdata),
        .core_stall_o(stall[1])
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model: a pending read is "busy until cycle done"; grants follow the arbitration rules directly.
    int   m_cyc[2]     = '{0, 0};
    int   m_done[2]    = '{0, 0};
    int   m_starve[2]  = '{0, 0};
    bit   m_busy[2]    = '{1'b0, 1'b0};
    bit   m_own_dma[2] = '{1'b0, 1'b0};
    logic e_cg, e_dg, e_crv, e_drv, e_ren, e_wen, e_st, pick_dma;
    logic [31:0] e_crd, e_drd, e_wd;
    logic [9:0]  e_addr;
    logic [2:0]  e_f3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_cg = 1'b0; e_dg = 1'b0; e_crv = 1'b0; e_drv = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
            e_st = 1'b0; e_crd = 32'h0; e_drd = 32'h0; e_wd = 32'h0; e_addr = 10'h0; e_f3 = 3'h0;
            if (rst_i) begin
                if (m_busy[i]) begin
                    if (m_cyc[i] == m_done[i]) begin
                        if (m_own_dma[i]) begin e_drv = 1'b1; e_drd = mem_rdata; end
                        else begin e_crv = 1'b1; e_crd = mem_rdata; end
                    end
                end else begin
                    pick_dma = dma_req && (!core_req || m_starve[i] == MB);
                    e_dg = pick_dma;
                    e_cg = core_req && !pick_dma;
                    if (e_cg) begin
                        e_ren = !core_we; e_wen = core_we; e_addr = core_addr; e_wd = core_wdata; e_f3 = core_f3;
                    end else if (e_dg) begin
                        e_ren = !dma_we; e_wen = dma_we; e_addr = dma_addr; e_wd = dma_wdata; e_f3 = dma_f3;
                    end
                end
                e_st = (core_req && !e_cg) || (m_busy[i] && !m_own_dma[i] && !e_crv);
            end
            chk1($sformatf("model L%0d core_gnt cyc%0d", lat_of(i), m_cyc[i]), core_gnt[i], e_cg);
            chk1($sformatf("model L%0d dma_gnt cyc%0d", lat_of(i), m_cyc[i]), dma_gnt[i], e_dg);
            chk1($sformatf("model L%0d core_rvalid cyc%0d", lat_of(i), m_cyc[i]), core_rvalid[i], e_crv);
            chk1($sformatf("model L%0d dma_rvalid cyc%0d", lat_of(i), m_cyc[i]), dma_rvalid[i], e_drv);
            chkv($sformatf("model L%0d core_rdata cyc%0d", lat_of(i), m_cyc[i]), core_rdata[i], e_crd);
            chkv($sformatf("model L%0d dma_rdata cyc%0d", lat_of(i), m_cyc[i]), dma_rdata[i], e_drd);
            chk1($sformatf("model L%0d mem_r_en cyc%0d", lat_of(i), m_cyc[i]), mem_ren[i], e_ren);
            chk1($sformatf("model L%0d mem_wr_en cyc%0d", lat_of(i), m_cyc[i]), mem_wen[i], e_wen);
            chkv($sformatf("model L%0d mem_addr cyc%0d", lat_of(i), m_cyc[i]), 32'(mem_addr[i]), 32'(e_addr));
            chkv($sformatf("model L%0d mem_wr_data cyc%0d", lat_of(i), m_cyc[i]), mem_wd[i], e_wd);
            chkv($sformatf("model L%0d mem_funct3 cyc%0d", lat_of(i), m_cyc[i]), 32'(mem_f3[i]), 32'(e_f3));
            chk1($sformatf("model L%0d core_stall cyc%0d", lat_of(i), m_cyc[i]), stall[i], e_st);
            // Advance the model across the coming rising edge.
            if (!rst_i) begin
                m_busy[i]   = 1'b0;
                m_starve[i] = 0;
            end else begin
                if (m_busy[i]) begin
                    if (m_cyc[i] == m_done[i]) m_busy[i] = 1'b0;
                end else if ((e_cg && !core_we) || (e_dg && !dma_we)) begin
                    m_busy[i]    = 1'b1;
                    m_own_dma[i] = e_dg;
                    m_done[i]    = m_cyc[i] + lat_of(i);
                end
                if (!dma_req || e_dg) m_starve[i] = 0;
                else if (e_cg && m_starve[i] < MB) m_starve[i] = m_starve[i] + 1;
            end
            m_cyc[i] = m_cyc[i] + 1;
        end
    end

    task automatic clear_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = 10'h0; core_wdata = 32'h0; core_f3 = 3'b000;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = 10'h0; dma_wdata  = 32'h0; dma_f3  = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        clear_inputs();
        core_req  = 1'b1;
        dma_req   = 1'b1;
        mem_rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("reset core_gnt", core_gnt[0], 1'b0);
            chk1("reset dma_gnt", dma_gnt[1], 1'b0);
            chk1("reset core_stall", stall[0], 1'b0);
            @(posedge clk); #1;
        end
        rst_i = 1'b1;
        clear_inputs();
        idle(3);

        // Core read then core write, ReadLatency 1.
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin core_req = 1'b1; core_we = 1'b0; core_addr = 10'h010; core_f3 = 3'b010;
                         mem_rdata = 32'hDEAD_BEEF; end
                1: core_req = 1'b0;
                2: begin core_req = 1'b1; core_we = 1'b1; core_addr = 10'h020;
                         core_wdata = 32'hA5A5_A5A5; core_f3 = 3'b010; end
                default: clear_inputs();
            endcase
            @(negedge clk);
            if (c == 0) begin
                chk1("rd core_gnt c0", core_gnt[0], 1'b1);
                chk1("rd mem_r_en c0", mem_ren[0], 1'b1);
                chkv("rd mem_addr c0", 32'(mem_addr[0]), 32'h010);
                chk1("rd stall c0", stall[0], 1'b0);
            end
            if (c == 1) begin
                chk1("rd core_rvalid c1", core_rvalid[0], 1'b1);
                chkv("rd core_rdata c1", core_rdata[0], 32'hDEAD_BEEF);
                chk1("rd stall c1", stall[0], 1'b0);
            end
            if (c == 2) begin
                chk1("rd core_rvalid c2", core_rvalid[0], 1'b0);
                chk1("wr core_gnt", core_gnt[0], 1'b1);
                chk1("wr mem_wr_en", mem_wen[0], 1'b1);
                chk1("wr mem_r_en", mem_ren[0], 1'b0);
                chkv("wr mem_addr", 32'(mem_addr[0]), 32'h020);
                chkv("wr mem_wr_data", mem_wd[0], 32'hA5A5_A5A5);
                chkv("wr mem_funct3", 32'(mem_f3[0]), 32'h2);
            end
            if (c == 3) begin
                chk1("wr mem_wr_en after", mem_wen[0], 1'b0);
                chk1("wr no rvalid", core_rvalid[0], 1'b0);
            end
            @(posedge clk); #1;
        end
        idle(6);

        // Both requesters hold reads: grant order core x4, DMA, core.
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h030; core_f3 = 3'b010;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 10'h200; dma_f3  = 3'b010;
        mem_rdata = 32'h1357_2468;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk1($sformatf("burst core_gnt c%0d", c), core_gnt[0], (c % 2 == 0) && (c != 8));
            chk1($sformatf("burst dma_gnt c%0d", c), dma_gnt[0], c == 8);
            if (c == 9) chkv("burst starve_cnt after dma", 32'(u_l1.starve_cnt_r), 32'h0);
            @(posedge clk); #1;
        end
        clear_inputs();
        idle(6);

        // DMA read at ReadLatency 3 while the core waits.
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h3FF; dma_f3 = 3'b100;
                         mem_rdata = 32'hCAFE_F00D; end
                1: begin dma_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 10'h044; end
                5: core_req = 1'b0;
                default: core_req = core_req;
            endcase
            @(negedge clk);
            if (c == 0) chk1("l3 dma_gnt c0", dma_gnt[1], 1'b1);
            if (c >= 1 && c <= 3) begin
                chk1($sformatf("l3 stall c%0d", c), stall[1], 1'b1);
                chk1($sformatf("l3 core_gnt c%0d", c), core_gnt[1], 1'b0);
            end
            if (c >= 1 && c <= 4) chk1($sformatf("l3 dma_rvalid c%0d", c), dma_rvalid[1], c == 3);
            if (c == 2) chkv("l3 dma_rdata idle", dma_rdata[1], 32'h0);
            if (c == 3) chkv("l3 dma_rdata c3", dma_rdata[1], 32'hCAFE_F00D);
            if (c == 4) begin
                chk1("l3 core_gnt c4", core_gnt[1], 1'b1);
                chk1("l3 stall c4", stall[1], 1'b0);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        idle(6);

        // Reset in the middle of a ReadLatency 3 read.
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin core_req = 1'b1; core_we = 1'b0; core_addr = 10'h055; end
                1: begin core_req = 1'b0; rst_i = 1'b0; end
                2: rst_i = 1'b1;
                3: begin core_req = 1'b1; core_we = 1'b1; core_addr = 10'h066;
                         core_wdata = 32'h0F0F_0F0F; core_f3 = 3'b010; end
                default: clear_inputs();
            endcase
            @(negedge clk);
            if (c == 1) chk1("rst core_stall in reset", stall[1], 1'b0);
            if (c >= 2) chk1($sformatf("rst no core_rvalid c%0d", c), core_rvalid[1], 1'b0);
            if (c == 2 || c >= 4) begin
                chk1($sformatf("rst mem_r_en c%0d", c), mem_ren[1], 1'b0);
                chk1($sformatf("rst mem_wr_en c%0d", c), mem_wen[1], 1'b0);
                chkv($sformatf("rst mem_addr c%0d", c), 32'(mem_addr[1]), 32'h0);
            end
            if (c == 3) begin
                chk1("rst idle grant c3", core_gnt[1], 1'b1);
                chk1("rst idle write c3", mem_wen[1], 1'b1);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        idle(6);

        // DMA request withdrawn during a core read wait.
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: begin core_req = 1'b1; core_we = 1'b0; core_addr = 10'h077; end
                1: begin core_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h100; end
                3: dma_req = 1'b0;
                default: dma_req = dma_req;
            endcase
            @(negedge clk);
            chk1($sformatf("wd dma_gnt c%0d", c), dma_gnt[1], 1'b0);
            if (c >= 1) begin
                chk1($sformatf("wd mem_r_en c%0d", c), mem_ren[1], 1'b0);
                chk1($sformatf("wd mem_wr_en c%0d", c), mem_wen[1], 1'b0);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
